// File: rtl/counter_nbit_multichannel.sv
// Bank of CHANNELS independent WIDTH-bit up/down counters with clear, load, tc pulse and sticky ovf.
// Define COUNTER_NBIT_MULTICHANNEL_SATURATE_EN to make counters saturate at the ends instead of wrapping.
module counter_nbit_multichannel #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       clr,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       ovf
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             tc_q, tc_d;
        logic             ovf_q, ovf_d;
        logic             at_max, at_zero;

        assign at_max  = &cnt_q;
        assign at_zero = ~|cnt_q;

        always_comb begin
            cnt_d = cnt_q;
            tc_d  = 1'b0;
            ovf_d = ovf_q;
            if (clr[ch]) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (load[ch]) begin
                cnt_d = load_val[ch*WIDTH +: WIDTH];
            end else if (en[ch]) begin
                // Stepping off either end is a boundary event; only the resulting value differs per build.
                if (dir[ch]) begin
                    if (at_max) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
`ifdef COUNTER_NBIT_MULTICHANNEL_SATURATE_EN
                        cnt_d = cnt_q;
`else
                        cnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    if (at_zero) begin
                        tc_d  = 1'b1;
                        ovf_d = 1'b1;
`ifdef COUNTER_NBIT_MULTICHANNEL_SATURATE_EN
                        cnt_d = cnt_q;
`else
                        cnt_d = '1;
`endif
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                tc_q  <= tc_d;
                ovf_q <= ovf_d;
            end
        end

        assign q[ch*WIDTH +: WIDTH] = cnt_q;
        assign tc[ch]               = tc_q;
        assign ovf[ch]              = ovf_q;
    end

endmodule
